// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register with stall, flush and event counters
// One register per stage boundary: load, bubble, hold or flush each cycle, plus saturating perf counters.
module pipe_stage_reg #(
  parameter int                   PAYLOAD_W  = 32,
  parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = '0,
  parameter int                   STAGE      = 2,
  parameter int                   CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall,
  input  logic                 flush,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_valid,
  input  logic                 cnt_clr,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_valid,
  output logic [CNT_W-1:0]     load_cnt,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     hold_cnt
);

  logic w_up;
  logic w_dn;
  logic w_do_load;
  logic w_do_bubble;
  logic w_do_hold;

  logic [PAYLOAD_W-1:0] r_payload;
  logic                 r_valid;
  logic [CNT_W-1:0]     r_load_cnt;
  logic [CNT_W-1:0]     r_bubble_cnt;
  logic [CNT_W-1:0]     r_hold_cnt;

  assign w_up = stall[STAGE];
  assign w_dn = stall[STAGE+1];

  // Flush is folded into the bubble event; up=0 loads even under the illegal dn=1 case.
  assign w_do_load   = !flush && !w_up;
  assign w_do_bubble = flush || (w_up && !w_dn);
  assign w_do_hold   = !flush && w_up && w_dn;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_payload <= BUBBLE_VAL;
      r_valid   <= 1'b0;
    end else if (w_do_bubble) begin
      r_payload <= BUBBLE_VAL;
      r_valid   <= 1'b0;
    end else if (w_do_load) begin
      r_payload <= in_payload;
      r_valid   <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_load_cnt   <= '0;
      r_bubble_cnt <= '0;
      r_hold_cnt   <= '0;
    end else begin
      if (w_do_load && !(&r_load_cnt))
        r_load_cnt <= r_load_cnt + 1'b1;
      if (w_do_bubble && !(&r_bubble_cnt))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (w_do_hold && !(&r_hold_cnt))
        r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  assign out_payload = r_payload;
  assign out_valid   = r_valid;
  assign load_cnt    = r_load_cnt;
  assign bubble_cnt  = r_bubble_cnt;
  assign hold_cnt    = r_hold_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
// A second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] in_payload;
  logic        in_valid;
  logic        cnt_clr;

  logic [31:0] out_payload;
  logic        out_valid;
  logic [15:0] load_cnt;
  logic [15:0] bubble_cnt;
  logic [15:0] hold_cnt;

  logic [31:0] s_payload;
  logic        s_valid;
  logic [1:0]  s_load_cnt;
  logic [1:0]  s_bubble_cnt;
  logic [1:0]  s_hold_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.PAYLOAD_W(32), .STAGE(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_payload(in_payload), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .out_payload(out_payload), .out_valid(out_valid),
    .load_cnt(load_cnt), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  pipe_stage_reg #(.PAYLOAD_W(32), .STAGE(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_payload(in_payload), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .out_payload(s_payload), .out_valid(s_valid),
    .load_cnt(s_load_cnt), .bubble_cnt(s_bubble_cnt), .hold_cnt(s_hold_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; the illegal up=0/dn=1 stall pattern must never be driven.
  task automatic step();
    assert (!(stall[2] == 1'b0 && stall[3] == 1'b1))
    else begin
      n_err++;
      $error("FAIL stall_legal observed=%0b expected=no up0/dn1", stall);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] p, input logic v);
    chk({tag, "_payload"}, out_payload, p);
    chk({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
  endtask

  task automatic chk_cnt(input string tag, input int l, input int b, input int h);
    chk({tag, "_load_cnt"}, {16'b0, load_cnt}, l);
    chk({tag, "_bubble_cnt"}, {16'b0, bubble_cnt}, b);
    chk({tag, "_hold_cnt"}, {16'b0, hold_cnt}, h);
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; cnt_clr = 1'b0;
    in_payload = 32'hDEADBEEF; in_valid = 1'b1;
    #1;
    step(); step();
    chk_out("reset", 32'h0, 1'b0);
    chk_cnt("reset", 0, 0, 0);
    rst = 1'b0;

    // Streaming
    for (int i = 1; i <= 4; i++) begin
      in_payload = i; step();
      chk_out($sformatf("stream%0d", i), i, 1'b1);
    end
    chk_cnt("stream", 4, 0, 0);

    // Bubble insert
    stall = 6'b000111; in_payload = 32'h55; step();
    chk_out("bubble", 32'h0, 1'b0);
    chk_cnt("bubble", 4, 1, 0);
    stall = 6'b000000; step();
    chk_out("after_bubble", 32'h55, 1'b1);

    // Hold
    in_payload = 32'hA5; step();
    chk_out("hold_load", 32'hA5, 1'b1);
    stall = 6'b001111;
    for (int i = 0; i < 3; i++) begin
      in_payload = 32'hA6 + i; step();
      chk_out($sformatf("hold%0d", i), 32'hA5, 1'b1);
    end
    chk_cnt("hold", 6, 1, 3);
    stall = 6'b000000; in_payload = 32'hB0; step();
    chk_out("hold_release", 32'hB0, 1'b1);

    // Flush overrides up=1,dn=1
    in_payload = 32'h77; step();
    stall = 6'b001111; in_payload = 32'h78; step();
    chk_out("held77", 32'h77, 1'b1);
    flush = 1'b1; step();
    chk_out("flush", 32'h0, 1'b0);
    chk_cnt("flush", 8, 2, 4);
    flush = 1'b0; step();
    chk_out("post_flush_hold", 32'h0, 1'b0);
    chk_cnt("post_flush_hold", 8, 2, 5);

    // Load with in_valid=0
    stall = 6'b000000; in_payload = 32'h44; in_valid = 1'b0; step();
    chk_out("invalid_load", 32'h44, 1'b0);
    in_valid = 1'b1;

    // cnt_clr during a hold leaves outputs untouched
    in_payload = 32'h33; step();
    stall = 6'b001111; cnt_clr = 1'b1; step();
    cnt_clr = 1'b0;
    chk_out("clr_hold", 32'h33, 1'b1);
    chk_cnt("clr_hold", 0, 0, 0);

    // Flush with cnt_clr
    stall = 6'b000000; in_payload = 32'h09; step();
    flush = 1'b1; cnt_clr = 1'b1; step();
    flush = 1'b0; cnt_clr = 1'b0;
    chk_out("flush_clr", 32'h0, 1'b0);
    chk_cnt("flush_clr", 0, 0, 0);

    // Reset mid-operation discards held contents
    in_payload = 32'h66; step();
    stall = 6'b001111; step();
    rst = 1'b1; step();
    rst = 1'b0; stall = 6'b000000;
    chk_out("mid_reset", 32'h0, 1'b0);
    chk_cnt("mid_reset", 0, 0, 0);

    // Saturation on the 2-bit instance
    for (int i = 0; i < 6; i++) begin
      in_payload = 32'h100 + i; step();
    end
    chk("sat_load_cnt", {30'b0, s_load_cnt}, 32'd3);
    chk("sat_wide_load_cnt", {16'b0, load_cnt}, 32'd6);
    chk("sat_payload", s_payload, 32'h105);
    in_payload = 32'h200; cnt_clr = 1'b1; step();
    cnt_clr = 1'b0;
    chk("sat_clr_load_cnt", {30'b0, s_load_cnt}, 32'd0);
    chk("sat_clr_payload", s_payload, 32'h200);
    in_payload = 32'h201; step();
    chk("sat_after_clr", {30'b0, s_load_cnt}, 32'd1);
    chk("sat_bubble_cnt", {30'b0, s_bubble_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
